control_pd_debug_cif_counters: RTL and testbench
================================================

// Module: control_pd_debug_cif_counters
// PURPOSE
//  CIF-side receiver for the PD debug matcher. Accumulates the matcher's increment pulses into packet/byte counters.
//  Holds sticky capture status; serves a single-outstanding CSR read port. Captured-PD words are fetched by driving
//  the word select back to the matcher and waiting out its multicycle mux. Sits between the debug matcher and CIF.
// PARAMETERS
//  PACKET_SIZE_WIDTH  12  width of dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount
//  PKT_CNT_WIDTH      32  packet/event counter width (<=32)
//  BYTE_CNT_WIDTH     48  byte counter width (33..64); read as lo/hi 32b halves
//  PD_MUX_SEL_WIDTH   2   width of captured-word select
//  PD_MUX_LATENCY     2   cycles from word_sel change to valid dbg2cif_c_debug_pd_out (>=1)
// PORTS
//  clk                                            in   1   clock
//  rst                                            in   1   synchronous reset, active-high
//  dbg2cif_e_debug_pd_total_pd_cnt_inc            in   1   total PD pulse
//  dbg2cif_e_debug_pd_field1_cnt_inc              in   1   field1 match pulse
//  dbg2cif_e_debug_pd_field2_cnt_inc              in   1   field2 match pulse
//  dbg2cif_e_debug_pd_capture_match_cnt_inc       in   1   capture_trigger pulse
//  dbg2cif_e_debug_pd_field1_byte_cnt_inc         in   1   add amount to field1 bytes
//  dbg2cif_e_debug_pd_field2_byte_cnt_inc         in   1   add amount to field2 bytes
//  dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount  in   PACKET_SIZE_WIDTH  byte amount
//  dbg2cif_e_debug_pd_capture_match_field1/2      in   1   each: capture pulse, sets sticky status
//  dbg2cif_c_debug_pd_out                         in   32  captured PD word from matcher mux
//  cif2dbg_c_debug_pd_captured_word_sel           out  PD_MUX_SEL_WIDTH  word index to matcher
//  cif_rd_req / cif_rd_clr                        in   1   read request pulse / clear-on-read qualifier
//  cif_rd_addr                                    in   4   read address
//  cif_clr_all                                    in   1   clear all counters, shadows, status
//  cif_rd_busy                                    out  1   read in flight; new req ignored
//  cif_rd_ack                                     out  1   one-cycle read completion pulse
//  cif_rd_data                                    out  32  read data, valid with ack, held until next ack
// BEHAVIOUR
//  Reset: all counters, hi shadows, sticky status, FSM=IDLE; ack=0, busy=0, rd_data=0, word_sel=0.
//  Counters: +1 per pulse; byte counters +amount (zero-extended). All saturate at all-ones, never wrap.
//  Address map: 0 total, 1 f1 cnt, 2 f2 cnt, 3 capture cnt, 4 f1 bytes lo, 5 f1 bytes hi shadow,
//   6 f2 bytes lo, 7 f2 bytes hi shadow, 8 status {30'b0,cap_f2,cap_f1}, 10..(10+2^SEL-1) captured word N, else 0.
//  Counters narrower than 32b are zero-extended.
//  Lo read atomically copies upper bits into hi shadow in the ack cycle, so lo-then-hi is coherent.
//  Hi read returns shadow only.
//  FSM IDLE->ACK for addr 0..9 and unmapped: req at cycle T, ack+data at T+1 (value as of T+1, pre-update).
//  FSM IDLE->WAIT->ACK for captured words: word_sel=addr-10 at T+1, hold PD_MUX_LATENCY cycles, sample, ack.
//  Captured-word ack occurs at T+1+PD_MUX_LATENCY. word_sel holds its last value after ack.
//  busy=1 from cycle after accepted req through the ack cycle; req while busy is dropped, no ack.
//  cif_rd_clr (sampled with req) on counter or status addr: target cleared in the ack cycle.
//   A same-cycle increment lands on the cleared value, e.g. count becomes 1 / amount, never lost.
//   Clr on a lo address clears the whole byte counter; clr on a hi address is ignored.
//  cif_clr_all: clears everything next cycle, wins over same-cycle increments; an in-flight read still
//   completes and reports post-clear value if its ack coincides or follows.
//  Sticky status bits set on capture pulse; set wins over same-cycle clear.
//  rst mid-read: FSM to IDLE, no ack issued.
// TESTING
//  1) Reset, read addr 0..8 -> each ack at T+1, data 0, busy low after ack.
//  2) 5 total pulses, 3 f1 with amount 0x100 -> addr0=5, addr1=3, addr4=0x300, addr5=0.
//  3) Preload f1 bytes to 0xFFFF_FFFF_FFF0, add 0x20 -> lo=0xFFFF_FFFF, hi shadow=0xFFFF (saturated).
//  4) Read addr1 with clr while f1 pulse same cycle -> rd_data=old count, count afterwards =1.
//  5) Read addr 12 -> word_sel=2 at T+1, ack at T+3 with dbg2cif_c_debug_pd_out; req at T+2 dropped.
//  6) capture_match_field2 pulse -> status=0x2; clr read -> 0x2 returned then 0x0; rst during WAIT -> no ack.

Source files
------------

// File: rtl/control_pd_debug_cif_counters.sv
// CIF-side receiver for the PD debug matcher: saturating packet/byte counters, sticky capture
// status and a single-outstanding CSR read port that can also fetch captured PD words.
module control_pd_debug_cif_counters #(
  parameter int PACKET_SIZE_WIDTH = 12,
  parameter int PKT_CNT_WIDTH     = 32,
  parameter int BYTE_CNT_WIDTH    = 48,
  parameter int PD_MUX_SEL_WIDTH  = 2,
  parameter int PD_MUX_LATENCY    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field1_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc,
  input  logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
  input  logic                         dbg2cif_e_debug_pd_capture_match_field1,
  input  logic                         dbg2cif_e_debug_pd_capture_match_field2,
  input  logic [31:0]                  dbg2cif_c_debug_pd_out,
  output logic [PD_MUX_SEL_WIDTH-1:0]  cif2dbg_c_debug_pd_captured_word_sel,
  input  logic                         cif_rd_req,
  input  logic                         cif_rd_clr,
  input  logic [3:0]                   cif_rd_addr,
  input  logic                         cif_clr_all,
  output logic                         cif_rd_busy,
  output logic                         cif_rd_ack,
  output logic [31:0]                  cif_rd_data
);

  localparam int NUM_WORDS = 1 << PD_MUX_SEL_WIDTH;
  localparam int LAT_W     = (PD_MUX_LATENCY > 1) ? $clog2(PD_MUX_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                      r_state;
  logic [3:0]                  r_addr;
  logic                        r_clr;
  logic [LAT_W-1:0]            r_wait;
  logic                        r_ack, r_busy;
  logic [31:0]                 r_rd_data;
  logic [PD_MUX_SEL_WIDTH-1:0] r_word_sel;

  logic [PKT_CNT_WIDTH-1:0]  r_total, r_f1_cnt, r_f2_cnt, r_cap_cnt;
  logic [BYTE_CNT_WIDTH-1:0] r_f1_bytes, r_f2_bytes;
  logic [31:0]               r_f1_hi, r_f2_hi;
  logic                      r_cap_f1, r_cap_f2;

  logic [PKT_CNT_WIDTH-1:0]  w_total_nxt, w_f1_cnt_nxt, w_f2_cnt_nxt, w_cap_cnt_nxt;
  logic [BYTE_CNT_WIDTH-1:0] w_f1_bytes_nxt, w_f2_bytes_nxt, w_amount;
  logic                      w_cap_f1_nxt, w_cap_f2_nxt;
  logic                      w_ack_clr, w_accept, w_is_cap, w_inc_en;
  logic [31:0]               w_rd_mux;

  function automatic logic [PKT_CNT_WIDTH-1:0] f_pkt_nxt(
    input logic [PKT_CNT_WIDTH-1:0] cur, input logic clr, input logic inc);
    logic [PKT_CNT_WIDTH-1:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != '1)) base = base + PKT_CNT_WIDTH'(1);
    return base;
  endfunction

  function automatic logic [BYTE_CNT_WIDTH-1:0] f_byte_nxt(
    input logic [BYTE_CNT_WIDTH-1:0] cur, input logic clr, input logic inc,
    input logic [BYTE_CNT_WIDTH-1:0] amt);
    logic [BYTE_CNT_WIDTH-1:0] base;
    logic [BYTE_CNT_WIDTH:0]   sum;
    base = clr ? '0 : cur;
    sum  = {1'b0, base} + {1'b0, amt};
    if (inc) base = sum[BYTE_CNT_WIDTH] ? '1 : sum[BYTE_CNT_WIDTH-1:0];
    return base;
  endfunction

  // Clear-on-read lands at the end of the ack cycle, so a same-cycle increment survives it.
  assign w_ack_clr = (r_state == S_ACK) && r_clr;
  assign w_inc_en  = !cif_clr_all;
  assign w_amount  = BYTE_CNT_WIDTH'(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount);
  assign w_accept  = (r_state == S_IDLE) && cif_rd_req;
  assign w_is_cap  = (cif_rd_addr >= 4'd10) && ((int'(cif_rd_addr) - 10) < NUM_WORDS);

  assign w_total_nxt    = f_pkt_nxt(r_total, cif_clr_all || (w_ack_clr && r_addr == 4'd0),
                                    w_inc_en && dbg2cif_e_debug_pd_total_pd_cnt_inc);
  assign w_f1_cnt_nxt   = f_pkt_nxt(r_f1_cnt, cif_clr_all || (w_ack_clr && r_addr == 4'd1),
                                    w_inc_en && dbg2cif_e_debug_pd_field1_cnt_inc);
  assign w_f2_cnt_nxt   = f_pkt_nxt(r_f2_cnt, cif_clr_all || (w_ack_clr && r_addr == 4'd2),
                                    w_inc_en && dbg2cif_e_debug_pd_field2_cnt_inc);
  assign w_cap_cnt_nxt  = f_pkt_nxt(r_cap_cnt, cif_clr_all || (w_ack_clr && r_addr == 4'd3),
                                    w_inc_en && dbg2cif_e_debug_pd_capture_match_cnt_inc);
  assign w_f1_bytes_nxt = f_byte_nxt(r_f1_bytes, cif_clr_all || (w_ack_clr && r_addr == 4'd4),
                                     w_inc_en && dbg2cif_e_debug_pd_field1_byte_cnt_inc, w_amount);
  assign w_f2_bytes_nxt = f_byte_nxt(r_f2_bytes, cif_clr_all || (w_ack_clr && r_addr == 4'd6),
                                     w_inc_en && dbg2cif_e_debug_pd_field2_byte_cnt_inc, w_amount);
  assign w_cap_f1_nxt = dbg2cif_e_debug_pd_capture_match_field1 |
                        (r_cap_f1 & ~(cif_clr_all | (w_ack_clr && r_addr == 4'd8)));
  assign w_cap_f2_nxt = dbg2cif_e_debug_pd_capture_match_field2 |
                        (r_cap_f2 & ~(cif_clr_all | (w_ack_clr && r_addr == 4'd8)));

  // Read data reflects the values visible in the ack cycle, before any clear-on-read.
  always_comb begin
    w_rd_mux = '0;
    case (cif_rd_addr)
      4'd0: w_rd_mux = 32'(w_total_nxt);
      4'd1: w_rd_mux = 32'(w_f1_cnt_nxt);
      4'd2: w_rd_mux = 32'(w_f2_cnt_nxt);
      4'd3: w_rd_mux = 32'(w_cap_cnt_nxt);
      4'd4: w_rd_mux = w_f1_bytes_nxt[31:0];
      4'd5: w_rd_mux = cif_clr_all ? '0 : r_f1_hi;
      4'd6: w_rd_mux = w_f2_bytes_nxt[31:0];
      4'd7: w_rd_mux = cif_clr_all ? '0 : r_f2_hi;
      4'd8: w_rd_mux = {30'b0, w_cap_f2_nxt, w_cap_f1_nxt};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_total    <= '0;
      r_f1_cnt   <= '0;
      r_f2_cnt   <= '0;
      r_cap_cnt  <= '0;
      r_f1_bytes <= '0;
      r_f2_bytes <= '0;
      r_f1_hi    <= '0;
      r_f2_hi    <= '0;
      r_cap_f1   <= 1'b0;
      r_cap_f2   <= 1'b0;
    end else begin
      r_total    <= w_total_nxt;
      r_f1_cnt   <= w_f1_cnt_nxt;
      r_f2_cnt   <= w_f2_cnt_nxt;
      r_cap_cnt  <= w_cap_cnt_nxt;
      r_f1_bytes <= w_f1_bytes_nxt;
      r_f2_bytes <= w_f2_bytes_nxt;
      r_cap_f1   <= w_cap_f1_nxt;
      r_cap_f2   <= w_cap_f2_nxt;
      if (cif_clr_all) begin
        r_f1_hi <= '0;
        r_f2_hi <= '0;
      end else if (w_accept && cif_rd_addr == 4'd4) begin
        r_f1_hi <= 32'(w_f1_bytes_nxt >> 32);
      end else if (w_accept && cif_rd_addr == 4'd6) begin
        r_f2_hi <= 32'(w_f2_bytes_nxt >> 32);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_clr      <= 1'b0;
      r_wait     <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_data  <= '0;
      r_word_sel <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cif_rd_req) begin
            r_busy <= 1'b1;
            r_addr <= cif_rd_addr;
            r_clr  <= cif_rd_clr;
            if (w_is_cap) begin
              r_word_sel <= PD_MUX_SEL_WIDTH'(cif_rd_addr - 4'd10);
              r_wait     <= LAT_W'(PD_MUX_LATENCY - 1);
              r_state    <= S_WAIT;
            end else begin
              r_rd_data <= w_rd_mux;
              r_ack     <= 1'b1;
              r_state   <= S_ACK;
            end
          end
        end
        S_WAIT: begin
          if (r_wait == '0) begin
            r_rd_data <= dbg2cif_c_debug_pd_out;
            r_ack     <= 1'b1;
            r_state   <= S_ACK;
          end else begin
            r_wait <= r_wait - LAT_W'(1);
          end
        end
        S_ACK: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cif2dbg_c_debug_pd_captured_word_sel = r_word_sel;
  assign cif_rd_busy = r_busy;
  assign cif_rd_ack  = r_ack;
  assign cif_rd_data = r_rd_data;

endmodule

// File: tb/tb_control_pd_debug_cif_counters.sv
// Directed bench for control_pd_debug_cif_counters: counters, saturation, clear-on-read,
// captured-word fetch through a latency-modelled matcher mux, sticky status and reset mid-read.
module tb_control_pd_debug_cif_counters;
  // Wide amount port lets the 48-bit byte counter reach its saturation region in a few hundred cycles.
  localparam int PSW = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           total_inc, f1_inc, f2_inc, capcnt_inc, f1b_inc, f2b_inc;
  logic [PSW-1:0] amount;
  logic           cap_f1, cap_f2;
  logic [31:0]    pd_out;
  logic [1:0]     word_sel, sel_d1;
  logic           rd_req, rd_clr, clr_all;
  logic [3:0]     rd_addr;
  logic           rd_busy, rd_ack;
  logic [31:0]    rd_data;
  int             n_chk = 0;
  int             n_err = 0;
  int             n_ack;

  always #5 clk = ~clk;

  control_pd_debug_cif_counters #(.PACKET_SIZE_WIDTH(PSW)) dut (
    .clk                                           (clk),
    .rst                                           (rst),
    .dbg2cif_e_debug_pd_total_pd_cnt_inc           (total_inc),
    .dbg2cif_e_debug_pd_field1_cnt_inc             (f1_inc),
    .dbg2cif_e_debug_pd_field2_cnt_inc             (f2_inc),
    .dbg2cif_e_debug_pd_capture_match_cnt_inc      (capcnt_inc),
    .dbg2cif_e_debug_pd_field1_byte_cnt_inc        (f1b_inc),
    .dbg2cif_e_debug_pd_field2_byte_cnt_inc        (f2b_inc),
    .dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount (amount),
    .dbg2cif_e_debug_pd_capture_match_field1       (cap_f1),
    .dbg2cif_e_debug_pd_capture_match_field2       (cap_f2),
    .dbg2cif_c_debug_pd_out                        (pd_out),
    .cif2dbg_c_debug_pd_captured_word_sel          (word_sel),
    .cif_rd_req                                    (rd_req),
    .cif_rd_clr                                    (rd_clr),
    .cif_rd_addr                                   (rd_addr),
    .cif_clr_all                                   (clr_all),
    .cif_rd_busy                                   (rd_busy),
    .cif_rd_ack                                    (rd_ack),
    .cif_rd_data                                   (rd_data)
  );

  // Matcher mux model: output is only valid once word_sel has been stable for a full cycle.
  always @(posedge clk) sel_d1 <= word_sel;
  always_comb pd_out = (sel_d1 == word_sel) ? (32'hC0DE_0000 | {30'b0, word_sel}) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic c, input logic [31:0] exp);
    rd_req = 1'b1; rd_addr = a; rd_clr = c;
    tick();
    rd_req = 1'b0; rd_clr = 1'b0;
    chk({tag, "_ack"}, rd_ack, 1'b1);
    chk({tag, "_data"}, rd_data, exp);
    tick();
    chk({tag, "_idle"}, {rd_ack, rd_busy}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    {total_inc, f1_inc, f2_inc, capcnt_inc, f1b_inc, f2b_inc} = '0;
    amount = '0; cap_f1 = 1'b0; cap_f2 = 1'b0;
    rd_req = 1'b0; rd_clr = 1'b0; rd_addr = '0; clr_all = 1'b0;
    repeat (3) tick();
    chk("rst_outs", {rd_ack, rd_busy, word_sel}, 4'b0000);
    chk("rst_data", rd_data, 32'h0);
    rst = 1'b0;
    tick();

    for (int a = 0; a <= 8; a++) rd_chk("t1_zero", 4'(a), 1'b0, 32'h0);

    // 5 total, 3 f1 (+0x100 bytes each), 2 f2 (+0x100 bytes each), 1 capture count
    for (int i = 0; i < 5; i++) begin
      total_inc = 1'b1; f1_inc = (i < 3); f1b_inc = (i < 3);
      f2_inc = (i < 2); f2b_inc = (i < 2); capcnt_inc = (i == 4); amount = 40'h100;
      tick();
    end
    {total_inc, f1_inc, f2_inc, capcnt_inc, f1b_inc, f2b_inc} = '0;
    rd_chk("t2_total", 4'd0, 1'b0, 32'd5);
    rd_chk("t2_f1",    4'd1, 1'b0, 32'd3);
    rd_chk("t2_f2",    4'd2, 1'b0, 32'd2);
    rd_chk("t2_cap",   4'd3, 1'b0, 32'd1);
    rd_chk("t2_f1lo",  4'd4, 1'b0, 32'h300);
    rd_chk("t2_f1hi",  4'd5, 1'b0, 32'h0);
    rd_chk("t2_f2lo",  4'd6, 1'b0, 32'h200);
    rd_chk("t2_unmap", 4'd9, 1'b0, 32'h0);

    // Clear-on-read with an increment in the ack cycle
    rd_req = 1'b1; rd_addr = 4'd1; rd_clr = 1'b1;
    tick();
    rd_req = 1'b0; rd_clr = 1'b0; f1_inc = 1'b1;
    chk("t4_ack", rd_ack, 1'b1);
    chk("t4_data", rd_data, 32'd3);
    tick();
    f1_inc = 1'b0;
    rd_chk("t4_after", 4'd1, 1'b0, 32'd1);

    // Captured word 2 via addr 12; a request while busy is dropped
    rd_req = 1'b1; rd_addr = 4'd12;
    tick();
    rd_req = 1'b0;
    chk("t5_sel", word_sel, 2'd2);
    chk("t5_t1", {rd_ack, rd_busy}, 2'b01);
    rd_req = 1'b1; rd_addr = 4'd0;
    tick();
    rd_req = 1'b0;
    chk("t5_t2", {rd_ack, rd_busy}, 2'b01);
    tick();
    chk("t5_ack", {rd_ack, rd_busy}, 2'b11);
    chk("t5_data", rd_data, 32'hC0DE_0002);
    n_ack = 0;
    repeat (3) begin tick(); n_ack += int'(rd_ack); end
    chk("t5_dropped", n_ack, 0);
    chk("t5_hold", word_sel, 2'd2);

    rd_req = 1'b1; rd_addr = 4'd10;
    tick();
    rd_req = 1'b0;
    chk("t5b_sel", word_sel, 2'd0);
    tick();
    chk("t5b_t2", rd_ack, 1'b0);
    tick();
    chk("t5b_ack", rd_ack, 1'b1);
    chk("t5b_data", rd_data, 32'hC0DE_0000);
    tick();
    rd_chk("t5_addr14", 4'd14, 1'b0, 32'h0);
    chk("t5_sel14", word_sel, 2'd0);

    // clr_all wins over a same-cycle increment
    clr_all = 1'b1; f1_inc = 1'b1; total_inc = 1'b1;
    tick();
    clr_all = 1'b0; f1_inc = 1'b0; total_inc = 1'b0;
    rd_chk("t3_clr_f1", 4'd1, 1'b0, 32'h0);
    rd_chk("t3_clr_tot", 4'd0, 1'b0, 32'h0);

    // 256 * (2^40-1) + 0xF0 = 0xFFFF_FFFF_FFF0
    f1b_inc = 1'b1; amount = 40'hFF_FFFF_FFFF;
    repeat (256) tick();
    amount = 40'hF0;
    tick();
    f1b_inc = 1'b0;
    rd_chk("t3_hi_stale", 4'd5, 1'b0, 32'h0);
    rd_chk("t3_lo_pre",   4'd4, 1'b0, 32'hFFFF_FFF0);
    rd_chk("t3_hi_pre",   4'd5, 1'b0, 32'h0000_FFFF);
    f1b_inc = 1'b1; amount = 40'h20;
    tick();
    f1b_inc = 1'b0;
    rd_chk("t3_lo_sat", 4'd4, 1'b0, 32'hFFFF_FFFF);
    rd_chk("t3_hi_sat", 4'd5, 1'b0, 32'h0000_FFFF);
    rd_chk("t3_lo_clr", 4'd4, 1'b1, 32'hFFFF_FFFF);
    rd_chk("t3_lo_zero", 4'd4, 1'b0, 32'h0);
    rd_chk("t3_hi_zero", 4'd5, 1'b0, 32'h0);

    // Sticky status, clear-on-read, then reset during a captured-word wait
    cap_f2 = 1'b1;
    tick();
    cap_f2 = 1'b0;
    rd_chk("t6_stat", 4'd8, 1'b0, 32'h2);
    rd_chk("t6_stat_clr", 4'd8, 1'b1, 32'h2);
    rd_chk("t6_stat_zero", 4'd8, 1'b0, 32'h0);

    rd_req = 1'b1; rd_addr = 4'd11;
    tick();
    rd_req = 1'b0;
    chk("t6_wait", {rd_busy, word_sel}, 3'b101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst", {rd_busy, word_sel}, 3'b000);
    n_ack = int'(rd_ack);
    repeat (4) begin tick(); n_ack += int'(rd_ack); end
    chk("t6_noack", n_ack, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
